// File: rtl/eth_rx_deframer.sv
// Receive deframer: strips preamble/SFD, forwards frame bytes, reports length and status.
// Define ETH_RX_FCS_CHECK_EN to add CRC-32 checking and FCS stripping via a 4-byte delay line.
module eth_rx_deframer #(
  parameter int MIN_PREAMBLE = 1,
  parameter int MAX_LEN      = 1522
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_rxen,
  input  logic [7:0]  in_rxd,
  output logic        out_dll_rxen,
  output logic [7:0]  out_dll_rxd,
  output logic        out_frame_done,
  output logic        out_frame_ok,
  output logic [15:0] out_frame_len,
  output logic        out_frame_err
);

  localparam logic [31:0] LP_MIN_PRE = MIN_PREAMBLE;
  localparam logic [31:0] LP_MAX_LEN = MAX_LEN;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_pre_cnt;
  logic [15:0] r_len;
  logic        r_dll_rxen;
  logic [7:0]  r_dll_rxd;
  logic        r_frame_done;
  logic        r_frame_ok;
  logic [15:0] r_frame_len;
  logic        r_frame_err;

  logic        w_sfd_ok;
  logic        w_sfd;
  logic        w_accept;
  logic        w_done_set;
  logic        w_err_set;
  logic        w_fwd;
  logic [7:0]  w_fwd_byte;
  logic        w_ok;

  assign w_sfd_ok = ({28'd0, r_pre_cnt} >= LP_MIN_PRE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (in_rxen) w_state_next = (in_rxd == 8'h55) ? S_PRE : S_DROP;
      end
      S_PRE: begin
        if (!in_rxen)                       w_state_next = S_IDLE;
        else if (in_rxd == 8'h55)           w_state_next = S_PRE;
        else if (in_rxd == 8'hD5 && w_sfd_ok) w_state_next = S_DATA;
        else                                w_state_next = S_DROP;
      end
      S_DATA: begin
        if (!in_rxen) w_state_next = S_IDLE;
      end
      S_DROP: begin
        if (!in_rxen) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Error fires on the transition into DROP, or when the wire goes quiet mid-preamble.
  always_comb begin
    w_accept   = (r_state == S_DATA) && in_rxen;
    w_sfd      = (r_state == S_PRE) && (w_state_next == S_DATA);
    w_done_set = (r_state == S_DATA) && !in_rxen;
    w_err_set  = ((r_state == S_PRE) && !in_rxen) ||
                 ((r_state != S_DROP) && (w_state_next == S_DROP));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= 4'd0;
      r_len     <= 16'd0;
    end else begin
      if (r_state == S_IDLE && w_state_next == S_PRE)
        r_pre_cnt <= 4'd1;
      else if (r_state == S_PRE && w_state_next == S_PRE && r_pre_cnt != 4'hF)
        r_pre_cnt <= r_pre_cnt + 4'd1;

      if (w_sfd)
        r_len <= 16'd0;
      else if (w_accept && r_len != 16'hFFFF)
        r_len <= r_len + 16'd1;
    end
  end

`ifdef ETH_RX_FCS_CHECK_EN
  logic [31:0]     r_crc;
  logic [3:0][7:0] r_dly;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] v;
    v = c;
    for (int i = 0; i < 8; i++)
      v = (v >> 1) ^ ((v[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return v;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= 32'hFFFFFFFF;
      r_dly <= '0;
    end else begin
      if (w_sfd)
        r_crc <= 32'hFFFFFFFF;
      else if (w_accept)
        r_crc <= crc_byte(r_crc, in_rxd);
      if (w_accept)
        r_dly <= {r_dly[2:0], in_rxd};
    end
  end

  // The oldest delayed byte leaves only once four newer bytes exist, so the FCS never escapes.
  assign w_fwd      = w_accept && (r_len >= 16'd4) && (({16'd0, r_len} - 32'd4) < LP_MAX_LEN);
  assign w_fwd_byte = r_dly[3];
  assign w_ok       = (r_crc == 32'hDEBB20E3) && (r_len >= 16'd4) && ({16'd0, r_len} <= LP_MAX_LEN);
`else
  assign w_fwd      = w_accept && ({16'd0, r_len} < LP_MAX_LEN);
  assign w_fwd_byte = in_rxd;
  assign w_ok       = ({16'd0, r_len} <= LP_MAX_LEN);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dll_rxen   <= 1'b0;
      r_dll_rxd    <= 8'h00;
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_len  <= 16'd0;
      r_frame_err  <= 1'b0;
    end else begin
      r_dll_rxen   <= w_fwd;
      r_dll_rxd    <= w_fwd ? w_fwd_byte : 8'h00;
      r_frame_done <= w_done_set;
      r_frame_ok   <= w_done_set && w_ok;
      r_frame_len  <= w_done_set ? r_len : 16'd0;
      r_frame_err  <= w_err_set;
    end
  end

  assign out_dll_rxen   = r_dll_rxen;
  assign out_dll_rxd    = r_dll_rxd;
  assign out_frame_done = r_frame_done;
  assign out_frame_ok   = r_frame_ok;
  assign out_frame_len  = r_frame_len;
  assign out_frame_err  = r_frame_err;

endmodule

// File: tb/tb_eth_rx_deframer.sv
// Bench for eth_rx_deframer: two parameterisations share one wire stream; a per-burst
// reference model fills per-cycle expectation tables that are checked every cycle.
module tb_eth_rx_deframer;

  localparam int NC = 4096;
`ifdef ETH_RX_FCS_CHECK_EN
  localparam int FCS_ON = 1;
`else
  localparam int FCS_ON = 0;
`endif

  logic              clock = 1'b0;
  logic              reset_n;
  logic              in_rxen;
  logic [7:0]        in_rxd;
  logic [1:0]        dll_rxen;
  logic [1:0][7:0]   dll_rxd;
  logic [1:0]        frame_done;
  logic [1:0]        frame_ok;
  logic [1:0][15:0]  frame_len;
  logic [1:0]        frame_err;

  eth_rx_deframer #(.MIN_PREAMBLE(1), .MAX_LEN(1522)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .in_rxen(in_rxen), .in_rxd(in_rxd),
    .out_dll_rxen(dll_rxen[0]), .out_dll_rxd(dll_rxd[0]),
    .out_frame_done(frame_done[0]), .out_frame_ok(frame_ok[0]),
    .out_frame_len(frame_len[0]), .out_frame_err(frame_err[0])
  );

  eth_rx_deframer #(.MIN_PREAMBLE(3), .MAX_LEN(8)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .in_rxen(in_rxen), .in_rxd(in_rxd),
    .out_dll_rxen(dll_rxen[1]), .out_dll_rxd(dll_rxd[1]),
    .out_frame_done(frame_done[1]), .out_frame_ok(frame_ok[1]),
    .out_frame_len(frame_len[1]), .out_frame_err(frame_err[1])
  );

  always #5 clock = ~clock;

  // Stimulus tables: entry t is what the wire shows at rising edge t.
  logic        s_en  [NC];
  logic [7:0]  s_d   [NC];
  logic        s_rst [NC];
  int          ncyc = 0;

  // Expected outputs visible in the cycle following edge t.
  logic        ex_v    [2][NC];
  logic [7:0]  ex_b    [2][NC];
  logic        ex_done [2][NC];
  logic        ex_ok   [2][NC];
  logic [15:0] ex_len  [2][NC];
  logic        ex_err  [2][NC];

  int min_pre [2] = '{1, 3};
  int max_len [2] = '{1522, 8};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int d, input int t,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, d, t, act, exp);
    end
  endtask

  task automatic put(input logic en, input logic [7:0] d, input logic rst);
    if (ncyc < NC) begin
      s_en[ncyc]  = en;
      s_d[ncyc]   = d;
      s_rst[ncyc] = rst;
      ncyc++;
    end
  endtask

  task automatic put_bytes(input logic [7:0] b[$]);
    foreach (b[i]) put(1'b1, b[i], 1'b0);
  endtask

  task automatic put_pre(input int n);
    repeat (n) put(1'b1, 8'h55, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 8'h00, 1'b0);
  endtask

  // Standard Ethernet CRC-32 (final value complemented) of a byte sequence.
  function automatic logic [31:0] crc32_q(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'd0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // One rxen-high burst from edge c0 to edge e (exclusive), judged from the framing rules.
  task automatic eval_burst(input int d, input int c0, input int e, input bit by_rst);
    int n, p, m, base, pc;
    logic ok;
    logic [7:0] pl[$];
    logic [7:0] body[$];
    n = e - c0;
    p = 0;
    while (p < n && s_d[c0+p] == 8'h55) p++;
    if (p == 0) begin ex_err[d][c0] = 1'b1; return; end
    if (p == n) begin
      if (!by_rst) ex_err[d][e] = 1'b1;
      return;
    end
    pc = (p > 15) ? 15 : p;
    if (s_d[c0+p] != 8'hD5 || pc < min_pre[d]) begin ex_err[d][c0+p] = 1'b1; return; end
    base = c0 + p + 1;
    m = n - p - 1;
    for (int j = 0; j < m; j++) pl.push_back(s_d[base+j]);
    ok = 1'b0;
    if (FCS_ON != 0) begin
      for (int j = 0; j < m - 4 && j < max_len[d]; j++) begin
        ex_v[d][base+j+4] = 1'b1;
        ex_b[d][base+j+4] = pl[j];
      end
      if (m >= 4 && m <= max_len[d]) begin
        body = pl;
        repeat (4) void'(body.pop_back());
        ok = (crc32_q(body) == {pl[m-1], pl[m-2], pl[m-3], pl[m-4]});
      end
    end else begin
      for (int j = 0; j < m && j < max_len[d]; j++) begin
        ex_v[d][base+j] = 1'b1;
        ex_b[d][base+j] = pl[j];
      end
      ok = (m <= max_len[d]);
    end
    if (!by_rst) begin
      ex_done[d][e] = 1'b1;
      ex_ok[d][e]   = ok;
      ex_len[d][e]  = m[15:0];
    end
  endtask

  function automatic int cnt(input int kind, input int d, input int a, input int b);
    int n;
    n = 0;
    for (int t = a; t <= b; t++) begin
      if (kind == 0 && ex_v[d][t])    n++;
      if (kind == 1 && ex_done[d][t]) n++;
      if (kind == 2 && ex_err[d][t])  n++;
    end
    return n;
  endfunction

  function automatic int first_v(input int d, input int a, input int b);
    for (int t = a; t <= b; t++) if (ex_v[d][t]) return t;
    return -1;
  endfunction

  int g_sfd, g_end, c_end, b_start, b_end, s_start, s_end, r_end, x_start, x_end, a_end;

  initial begin
    logic [7:0] gp[$];
    logic [7:0] gbad[$];
    logic [7:0] runt[$];
    logic [7:0] pl[$];
    logic [7:0] c9[$];
    logic [31:0] c;
    int inb, c0, npre, kind, k;

    for (int d = 0; d < 2; d++)
      for (int t = 0; t < NC; t++) begin
        ex_v[d][t] = 0; ex_b[d][t] = 0; ex_done[d][t] = 0;
        ex_ok[d][t] = 0; ex_len[d][t] = 0; ex_err[d][t] = 0;
      end

    gp   = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    gbad = gp;
    gbad[12] = 8'hCA;
    runt = {8'h01, 8'h02};

    repeat (3) put(1'b0, 8'h00, 1'b1);
    idle(2);
    put_pre(7); g_sfd = ncyc; put(1'b1, 8'hD5, 1'b0); put_bytes(gp); g_end = ncyc; idle(1);
    put_pre(7); put(1'b1, 8'hD5, 1'b0); put_bytes(gbad); c_end = ncyc; idle(1);
    b_start = ncyc; put_pre(2); put_bytes({8'hAB, 8'h11, 8'h22}); b_end = ncyc; idle(1);
    s_start = ncyc; put_pre(1); put(1'b1, 8'hD5, 1'b0); put_bytes(gp); s_end = ncyc; idle(1);
    put_pre(7); put(1'b1, 8'hD5, 1'b0); put_bytes(gp); idle(1);
    put_pre(1); put(1'b1, 8'hD5, 1'b0); put_bytes(runt); r_end = ncyc; idle(2);
    put_pre(4); idle(1);
    x_start = ncyc; put_pre(7); put(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 5; i++) put(1'b1, gp[i], 1'b0);
    repeat (2) put(1'b0, 8'h00, 1'b1);
    x_end = ncyc; idle(2);
    put_pre(7); put(1'b1, 8'hD5, 1'b0); put_bytes(gp); a_end = ncyc; idle(2);

    for (int f = 0; f < 60 && ncyc < NC - 80; f++) begin
      kind = $urandom_range(0, 9);
      npre = $urandom_range(0, 18);
      if (kind == 0 && npre == 0) npre = 1;
      put_pre(npre);
      if (kind != 0) begin
        put(1'b1, (kind == 1) ? 8'($urandom_range(0, 255)) : 8'hD5, 1'b0);
        pl.delete();
        k = $urandom_range(0, 16);
        for (int i = 0; i < k; i++) pl.push_back(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 3) != 0) begin
          c = crc32_q(pl);
          pl.push_back(c[7:0]); pl.push_back(c[15:8]);
          pl.push_back(c[23:16]); pl.push_back(c[31:24]);
        end else begin
          k = $urandom_range(0, 4);
          for (int i = 0; i < k; i++) pl.push_back(8'($urandom_range(0, 255)));
        end
        put_bytes(pl);
      end
      idle($urandom_range(1, 3));
    end
    idle(5);

    for (int d = 0; d < 2; d++) begin
      inb = 0; c0 = 0;
      for (int t = 0; t < ncyc; t++) begin
        if (s_rst[t]) begin
          if (inb != 0) eval_burst(d, c0, t, 1'b1);
          inb = 0;
        end else if (s_en[t]) begin
          if (inb == 0) begin inb = 1; c0 = t; end
        end else if (inb != 0) begin
          eval_burst(d, c0, t, 1'b0);
          inb = 0;
        end
      end
    end

    // Hand-derived values that pin the model itself.
    c9 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c = crc32_q(c9);
    chk("pin_crc_lo", 0, -1, c[15:0], 16'h3926);
    chk("pin_crc_hi", 0, -1, c[31:16], 16'hCBF4);
    chk("pin_good_done", 0, g_end, 16'(ex_done[0][g_end]), 16'd1);
    chk("pin_good_len", 0, g_end, ex_len[0][g_end], 16'd13);
    chk("pin_good_ok", 0, g_end, 16'(ex_ok[0][g_end]), 16'd1);
    chk("pin_good_fwd_cnt", 0, g_end, 16'(cnt(0, 0, g_sfd, g_end)), (FCS_ON != 0) ? 16'd9 : 16'd13);
    chk("pin_good_first_fwd", 0, g_sfd, 16'(first_v(0, g_sfd, g_end) - g_sfd),
        (FCS_ON != 0) ? 16'd5 : 16'd1);
    chk("pin_big_ok", 1, g_end, 16'(ex_ok[1][g_end]), 16'd0);
    chk("pin_big_len", 1, g_end, ex_len[1][g_end], 16'd13);
    chk("pin_big_fwd_cnt", 1, g_end, 16'(cnt(0, 1, g_sfd, g_end)), 16'd8);
    chk("pin_crcbad_ok", 0, c_end, 16'(ex_ok[0][c_end]), (FCS_ON != 0) ? 16'd0 : 16'd1);
    chk("pin_badpre_err", 0, b_start, 16'(cnt(2, 0, b_start, b_end)), 16'd1);
    chk("pin_badpre_done", 0, b_start, 16'(cnt(1, 0, b_start, b_end)), 16'd0);
    chk("pin_shortpre_err", 1, s_start, 16'(cnt(2, 1, s_start, s_end)), 16'd1);
    chk("pin_shortpre_done0", 0, s_end, 16'(ex_done[0][s_end]), 16'd1);
    chk("pin_runt_len", 0, r_end, ex_len[0][r_end], 16'd2);
    chk("pin_runt_ok", 0, r_end, 16'(ex_ok[0][r_end]), (FCS_ON != 0) ? 16'd0 : 16'd1);
    chk("pin_runt_fwd_cnt", 0, r_end, 16'(cnt(0, 0, r_end - 4, r_end)), (FCS_ON != 0) ? 16'd0 : 16'd2);
    chk("pin_rst_no_done", 0, x_start, 16'(cnt(1, 0, x_start, x_end + 1)), 16'd0);
    chk("pin_after_rst_ok", 0, a_end, 16'(ex_ok[0][a_end]), 16'd1);

    for (int t = 0; t < ncyc; t++) begin
      reset_n = ~s_rst[t];
      in_rxen = s_en[t];
      in_rxd  = s_d[t];
      @(posedge clock);
      #1;
    end
  end

  // Compare process: the cycle after edge t is checked at the following falling edge.
  initial begin
    bit z;
    @(negedge clock);
    for (int t = 0; t < ncyc; t++) begin
      if (t > 0) @(negedge clock);
      z = s_rst[t] || (t + 1 < ncyc && s_rst[t+1]);
      for (int d = 0; d < 2; d++) begin
        chk("dll_rxen", d, t, 16'(dll_rxen[d]), z ? 16'd0 : 16'(ex_v[d][t]));
        if (z || ex_v[d][t])
          chk("dll_rxd", d, t, 16'(dll_rxd[d]), z ? 16'd0 : 16'(ex_b[d][t]));
        chk("frame_done", d, t, 16'(frame_done[d]), z ? 16'd0 : 16'(ex_done[d][t]));
        chk("frame_ok", d, t, 16'(frame_ok[d]), z ? 16'd0 : 16'(ex_ok[d][t]));
        chk("frame_len", d, t, frame_len[d], z ? 16'd0 : ex_len[d][t]);
        chk("frame_err", d, t, 16'(frame_err[d]), z ? 16'd0 : 16'(ex_err[d][t]));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
